// File: rtl/edge_threshold_pkg.sv
// Shared defaults, pixel constants and width helper for the filter op stages.
package edge_threshold_pkg;

    localparam int unsigned DEF_DWIDTH     = 8;
    localparam int unsigned DEF_IMG_WIDTH  = 720;
    localparam int unsigned DEF_IMG_HEIGHT = 540;

    // Binarized pixel levels shared by thresholding and morphology stages.
    localparam logic [DEF_DWIDTH-1:0] PIX_ON  = '1;
    localparam logic [DEF_DWIDTH-1:0] PIX_OFF = '0;

    // Bits needed to index 0..value-1; never returns less than 1.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned w;
        w = 1;
        while ((64'd1 << w) < 64'(value)) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/edge_threshold_position.sv
// Raster position tracker: col/row counters with frame wrap, first/last
// pixel flags and a border flag for masking BORDER pixels at each edge.
module pixel_position_counter
    import edge_threshold_pkg::*;
#(
    parameter int unsigned IMG_WIDTH  = DEF_IMG_WIDTH,
    parameter int unsigned IMG_HEIGHT = DEF_IMG_HEIGHT,
    parameter int unsigned BORDER     = 1
) (
    input  logic clock,
    input  logic reset,
    input  logic advance,
    output logic first,
    output logic last,
    output logic border
);

    localparam int unsigned CW = clog2(IMG_WIDTH);
    localparam int unsigned RW = clog2(IMG_HEIGHT);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic          col_end;
    logic          row_end;

    assign col_end = (col == COL_LAST);
    assign row_end = (row == ROW_LAST);
    assign first   = (col == '0) && (row == '0);
    assign last    = col_end && row_end;

    // Step through the raster on each accepted pixel, wrapping at row and frame end.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            col <= '0;
            row <= '0;
        end else if (advance) begin
            if (col_end) begin
                col <= '0;
                row <= row_end ? '0 : row + RW'(1);
            end else begin
                col <= col + CW'(1);
            end
        end
    end

    generate
        if (BORDER == 0) begin : g_no_border
            assign border = 1'b0;
        end else begin : g_border
            localparam logic [CW-1:0] COL_LO = CW'(BORDER);
            localparam logic [CW-1:0] COL_HI = CW'(IMG_WIDTH - BORDER);
            localparam logic [RW-1:0] ROW_LO = RW'(BORDER);
            localparam logic [RW-1:0] ROW_HI = RW'(IMG_HEIGHT - BORDER);
            assign border = (col < COL_LO) || (col >= COL_HI) ||
                            (row < ROW_LO) || (row >= ROW_HI);
        end
    endgenerate

endmodule

// File: rtl/edge_threshold.sv
// Binarizes Sobel magnitudes against a per-frame threshold, masks the image
// border, forwards results through a one-entry output register and reports
// the edge-pixel count of each completed frame.
module edge_threshold
    import edge_threshold_pkg::*;
#(
    parameter int unsigned IMG_WIDTH  = DEF_IMG_WIDTH,
    parameter int unsigned IMG_HEIGHT = DEF_IMG_HEIGHT,
    parameter int unsigned DWIDTH     = DEF_DWIDTH,
    parameter int unsigned BORDER     = 1,
    parameter int unsigned CNT_WIDTH  = 20
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [DWIDTH-1:0]    threshold,
    output logic                 fifo_in_rd_en,
    input  logic [DWIDTH-1:0]    fifo_in_dout,
    input  logic                 fifo_in_empty,
    output logic                 fifo_out_wr_en,
    output logic [DWIDTH-1:0]    fifo_out_din,
    input  logic                 fifo_out_full,
    output logic                 frame_done,
    output logic [CNT_WIDTH-1:0] edge_count
);

    logic                 out_valid;
    logic [DWIDTH-1:0]    out_data;
    logic [DWIDTH-1:0]    thr_q;
    logic [DWIDTH-1:0]    thr;
    logic [DWIDTH-1:0]    result;
    logic [CNT_WIDTH-1:0] running;
    logic                 accept;
    logic                 edge_px;
    logic                 first_px;
    logic                 last_px;
    logic                 border_px;

    pixel_position_counter #(
        .IMG_WIDTH  (IMG_WIDTH),
        .IMG_HEIGHT (IMG_HEIGHT),
        .BORDER     (BORDER)
    ) u_pos (
        .clock   (clock),
        .reset   (reset),
        .advance (accept),
        .first   (first_px),
        .last    (last_px),
        .border  (border_px)
    );

    // Pop whenever a pixel is available and the output register is free or
    // draining this cycle; held low while in reset so no pixel is lost.
    assign accept         = ~reset & ~fifo_in_empty & (~out_valid | ~fifo_out_full);
    assign fifo_in_rd_en  = accept;
    assign fifo_out_wr_en = out_valid & ~fifo_out_full;
    assign fifo_out_din   = out_data;

    // Threshold compare against the live input on the first pixel, latched value after.
    always_comb begin
        thr     = first_px ? threshold : thr_q;
        edge_px = ~border_px & (fifo_in_dout >= thr);
        result  = edge_px ? '1 : '0;
    end

    // Output register: refill on accept, otherwise empty once pushed downstream.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= result;
        end else if (fifo_out_wr_en) begin
            out_valid <= 1'b0;
        end
    end

    // Latch the frame threshold when the first pixel of a frame is taken.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            thr_q <= '0;
        end else if (accept && first_px) begin
            thr_q <= threshold;
        end
    end

    // Per-frame edge count, published with a one-cycle done pulse at frame end.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            running    <= '0;
            edge_count <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (accept) begin
                if (last_px) begin
                    edge_count <= running + CNT_WIDTH'(edge_px);
                    running    <= '0;
                    frame_done <= 1'b1;
                end else begin
                    running <= running + CNT_WIDTH'(edge_px);
                end
            end
        end
    end

endmodule

// File: tb/tb_edge_threshold.sv
// Bench for edge_threshold on a 5x4 image with a 1-pixel border.
module tb_edge_threshold;

    localparam int W = 5;
    localparam int H = 4;
    localparam int B = 1;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] threshold;
    logic       fifo_in_rd_en;
    logic [7:0] fifo_in_dout;
    logic       fifo_in_empty;
    logic       fifo_out_wr_en;
    logic [7:0] fifo_out_din;
    logic       fifo_out_full;
    logic       frame_done;
    logic [7:0] edge_count;

    edge_threshold #(
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H),
        .DWIDTH     (8),
        .BORDER     (B),
        .CNT_WIDTH  (8)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .threshold      (threshold),
        .fifo_in_rd_en  (fifo_in_rd_en),
        .fifo_in_dout   (fifo_in_dout),
        .fifo_in_empty  (fifo_in_empty),
        .fifo_out_wr_en (fifo_out_wr_en),
        .fifo_out_din   (fifo_out_din),
        .fifo_out_full  (fifo_out_full),
        .frame_done     (frame_done),
        .edge_count     (edge_count)
    );

    always #5 clock = ~clock;

    int n_pass  = 0;
    int n_total = 0;

    // Upstream FIFO contents and test-level knobs.
    logic [7:0] q[$];
    int         accepted;
    int         sw_at;
    logic [7:0] thr_a, thr_b;
    int         full_start, full_len;
    int         fd_seen, dut_pushes;

    // Behavioural model: frame index, one-slot output buffer, counts.
    bit         m_occ;
    logic [7:0] m_data;
    logic [7:0] m_thr;
    int         m_idx, m_run, m_ec;
    bit         m_fd;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic model_reset();
        m_occ = 0; m_data = '0; m_thr = '0;
        m_idx = 0; m_run = 0; m_ec = 0; m_fd = 0;
    endtask

    // One clock: compare at negedge, advance model, then pop upstream after posedge.
    task automatic cycle();
        bit acc;
        int c, r, e;
        bit brd;
        logic [7:0] t;
        acc = 0;
        @(negedge clock);
        if (frame_done === 1'b1) fd_seen++;
        if (fifo_out_wr_en === 1'b1) dut_pushes++;
        if (reset) begin
            chk("rst_rd_en", 32'(fifo_in_rd_en), 0);
            chk("rst_wr_en", 32'(fifo_out_wr_en), 0);
            chk("rst_din", 32'(fifo_out_din), 0);
            chk("rst_frame_done", 32'(frame_done), 0);
            chk("rst_edge_count", 32'(edge_count), 0);
            model_reset();
        end else begin
            acc = !fifo_in_empty && (!m_occ || !fifo_out_full);
            chk("rd_en", 32'(fifo_in_rd_en), 32'(acc));
            chk("wr_en", 32'(fifo_out_wr_en), 32'(m_occ && !fifo_out_full));
            if (m_occ && !fifo_out_full) chk("din", 32'(fifo_out_din), 32'(m_data));
            chk("frame_done", 32'(frame_done), 32'(m_fd));
            chk("edge_count", 32'(edge_count), 32'(m_ec));
            m_fd = 0;
            if (acc) begin
                c   = m_idx % W;
                r   = m_idx / W;
                brd = (c < B) || (c >= W - B) || (r < B) || (r >= H - B);
                t   = (m_idx == 0) ? threshold : m_thr;
                if (m_idx == 0) m_thr = threshold;
                e      = (!brd && fifo_in_dout >= t) ? 1 : 0;
                m_occ  = 1;
                m_data = e ? 8'hFF : 8'h00;
                if (m_idx == W * H - 1) begin
                    m_ec  = m_run + e;
                    m_run = 0;
                    m_fd  = 1;
                    m_idx = 0;
                end else begin
                    m_run = m_run + e;
                    m_idx = m_idx + 1;
                end
                accepted++;
            end else if (m_occ && !fifo_out_full) begin
                m_occ = 0;
            end
        end
        @(posedge clock);
        #1;
        if (acc) void'(q.pop_front());
    endtask

    // kind 0: repeating 0,99,100,255; 1: all 255; 2: random
    task automatic load(input int kind, input int n);
        logic [7:0] pat [4];
        pat[0] = 8'd0; pat[1] = 8'd99; pat[2] = 8'd100; pat[3] = 8'd255;
        for (int k = 0; k < n; k++) begin
            if (kind == 0)      q.push_back(pat[k % 4]);
            else if (kind == 1) q.push_back(8'hFF);
            else                q.push_back(8'($urandom));
        end
    endtask

    task automatic run(input int gap_pct, input int full_pct, input int stop_acc);
        int cyc;
        cyc = 0;
        while (!(q.size() == 0 && !m_occ) && accepted < stop_acc) begin
            if (cyc >= 1000) begin
                chk("timeout", 1, 0);
                break;
            end
            fifo_in_empty = (q.size() == 0) || (int'($urandom_range(99)) < gap_pct);
            fifo_in_dout  = fifo_in_empty ? 8'($urandom) : q[0];
            threshold     = (accepted >= sw_at) ? thr_b : thr_a;
            fifo_out_full = (cyc >= full_start && cyc < full_start + full_len) ||
                            (int'($urandom_range(99)) < full_pct);
            cycle();
            cyc++;
        end
        fifo_in_empty = 1'b1;
        fifo_out_full = 1'b0;
    endtask

    task automatic start_test(input logic [7:0] ta, input logic [7:0] tb, input int sw);
        accepted = 0; thr_a = ta; thr_b = tb; sw_at = sw;
        full_start = 0; full_len = 0; fd_seen = 0; dut_pushes = 0;
    endtask

    initial begin
        model_reset();
        reset = 1'b1; threshold = 8'd0; fifo_in_dout = 8'd0;
        fifo_in_empty = 1'b1; fifo_out_full = 1'b0;
        start_test(8'd0, 8'd0, 1000);
        #1;
        for (int i = 0; i < 3; i++) cycle();
        reset = 1'b0;

        // Pattern frame, no stalls: interior holds 100,255,0 / 255,0,99 -> 3 edges.
        start_test(8'd100, 8'd100, 1000);
        load(0, W * H);
        run(0, 0, 1000);
        chk("t1_edge_count", 32'(edge_count), 3);
        chk("t1_frame_pulses", 32'(fd_seen), 1);
        chk("t1_pushes", 32'(dut_pushes), W * H);

        // All 255 at threshold 0: only the 3x2 interior is set.
        start_test(8'd0, 8'd0, 1000);
        load(1, W * H);
        run(0, 0, 1000);
        chk("t2_edge_count", 32'(edge_count), 6);

        // Downstream full for 5 cycles mid-frame.
        start_test(8'd100, 8'd100, 1000);
        full_start = 6; full_len = 5;
        load(0, W * H);
        run(0, 0, 1000);
        chk("t3_edge_count", 32'(edge_count), 3);
        chk("t3_pushes", 32'(dut_pushes), W * H);

        // Threshold moves 100 -> 200 at pixel 5; the running frame keeps 100.
        start_test(8'd100, 8'd200, 5);
        load(0, 2 * W * H);
        run(0, 0, W * H + 1);
        chk("t4_frame1_count", 32'(edge_count), 3);
        run(0, 0, 1000);
        chk("t4_frame2_count", 32'(edge_count), 2);
        chk("t4_frame_pulses", 32'(fd_seen), 2);

        // 30% upstream gaps plus random backpressure.
        start_test(8'd100, 8'd100, 1000);
        load(0, W * H);
        run(30, 20, 1000);
        chk("t5_edge_count", 32'(edge_count), 3);
        chk("t5_pushes", 32'(dut_pushes), W * H);

        // Reset after 7 pixels, then a fresh all-255 frame at threshold 0.
        start_test(8'd100, 8'd100, 1000);
        load(0, W * H);
        run(0, 0, 7);
        q.delete();
        reset = 1'b1;
        fifo_in_empty = 1'b0; fifo_in_dout = 8'hFF;
        for (int i = 0; i < 3; i++) cycle();
        reset = 1'b0;
        fifo_in_empty = 1'b1;
        start_test(8'd0, 8'd0, 1000);
        load(1, W * H);
        run(0, 0, 1000);
        chk("t6_edge_count", 32'(edge_count), 6);
        chk("t6_frame_pulses", 32'(fd_seen), 1);

        // Random data and thresholds over several frames with gaps and stalls.
        for (int f = 0; f < 4; f++) begin
            start_test(8'($urandom), 8'($urandom), int'($urandom_range(W * H - 1)));
            load(2, W * H);
            run(25, 25, 1000);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
